// File: rtl/spi_byte_rx.sv
// spi_byte_rx: mode-0 SPI slave receiver; synchronises the pads into clk,
// deserialises MSB-first words and shifts a status word back on miso.
module spi_byte_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              busy,
  output logic              frame_err
);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync, warm;
  logic sck_s, mosi_s, ss_s, sck_d, ss_d, armed;
  logic sck_rise, sck_fall, ss_rise, ss_fall, start, last_bit;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;
  // armed only once the chains carry real pad values and ss was seen high,
  // so a low ss at reset release cannot masquerade as a falling edge
  assign start    = ss_fall & armed;
  assign last_bit = bit_cnt == BW'(DATA_W - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      warm      <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
      armed     <= armed | (warm[SYNC_STAGES-1] & ss_s);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = SHIFT;
    else if (state == SHIFT && ss_rise) state_nxt = IDLE;
  end
  always_comb begin
    busy = state == SHIFT;
    miso = busy & tx_shift[DATA_W-1];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      byte_cnt  <= '0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
          tx_shift <= tx_data;
        end
      end else if (ss_rise) begin
        frame_err <= bit_cnt != '0;
        bit_cnt   <= '0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
        bit_cnt  <= last_bit ? '0 : bit_cnt + BW'(1);
        if (last_bit) begin
          rx_data  <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
          byte_cnt <= byte_cnt + CNT_W'(1);
          tx_shift <= tx_data;
        end
      end else if (sck_fall && bit_cnt != '0) begin
        // the fall right after a reload is skipped so the new MSB is not lost
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_spi_byte_rx.sv
// tb_spi_byte_rx: drives mode-0 SPI frames and checks received words,
// frame counts, miso bits and error pulses against a queue-based model.
module tb_spi_byte_rx;
  logic clk = 0, rst = 0, sck = 0, mosi = 0, ss = 1;
  logic [7:0] tx_data = 0;
  logic miso, rx_valid, busy, frame_err;
  logic [7:0] rx_data;
  logic [3:0] byte_cnt;
  int n_cmp = 0, n_fail = 0, ferr_seen = 0;
  bit idle_act = 0, both_seen = 0;
  logic [11:0] rxq[$];
  logic miso_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] last_rx = 0;

  spi_byte_rx dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss), .miso(miso),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .byte_cnt(byte_cnt), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxq.push_back({byte_cnt, rx_data});
    if (frame_err) ferr_seen++;
    if (rx_valid && frame_err) both_seen = 1;
    if (busy || miso || rx_valid) idle_act = 1;
  end

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #20 sck = 1;
      #19 miso_q.push_back(miso);
      #1 sck = 0;
    end
  endtask

  task automatic frame_start;
    @(posedge clk);
    #5 ss = 0;
    #60;
  endtask

  task automatic frame_end;
    #40 ss = 1;
    #80;
  endtask

  task automatic test_reset;
    rst = 0;
    #23;
    n_cmp++;
    if ({rx_data, rx_valid, byte_cnt, busy, frame_err, miso} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rx_data=%h rx_valid=%b byte_cnt=%0d busy=%b frame_err=%b miso=%b want all 0",
               rx_data, rx_valid, byte_cnt, busy, frame_err, miso);
    end
    rst = 1;
    #100;
  endtask

  task automatic test_frame(input string name, input logic [7:0] tx);
    logic [11:0] exp;
    rxq.delete(); miso_q.delete(); ferr_seen = 0; tx_data = tx;
    frame_start();
    foreach (frame_q[k]) send_bits(frame_q[k], 8);
    frame_end();
    n_cmp++;
    if (rxq.size() != frame_q.size()) begin
      n_fail++;
      $display("FAIL %s rx_count: got %0d want %0d", name, rxq.size(), frame_q.size());
    end
    foreach (frame_q[k]) if (k < rxq.size()) begin
      exp = {4'((k + 1) % 16), frame_q[k]};
      n_cmp++;
      if (rxq[k] !== exp) begin
        n_fail++;
        $display("FAIL %s byte%0d: got cnt=%0d data=%h want cnt=%0d data=%h",
                 name, k, rxq[k][11:8], rxq[k][7:0], exp[11:8], exp[7:0]);
      end
    end
    for (int k = 0; k < frame_q.size(); k++)
      for (int j = 0; j < 8; j++) begin
        n_cmp++;
        if (miso_q[k*8+j] !== tx[7-j]) begin
          n_fail++;
          $display("FAIL %s miso byte%0d bit%0d: got %b want %b", name, k, j, miso_q[k*8+j], tx[7-j]);
        end
      end
    n_cmp++;
    if (byte_cnt !== 4'(frame_q.size() % 16)) begin
      n_fail++;
      $display("FAIL %s byte_cnt_hold: got %0d want %0d", name, byte_cnt, frame_q.size() % 16);
    end
    n_cmp++;
    if (ferr_seen != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_state: got frame_err_pulses=%0d busy=%b want 0 and 0", name, ferr_seen, busy);
    end
    if (frame_q.size() > 0) last_rx = frame_q[frame_q.size()-1];
  endtask

  task automatic test_idle_noise;
    ss = 1; rxq.delete();
    @(posedge clk);
    #5 idle_act = 0;
    repeat (16) begin
      mosi = 1'($urandom);
      #20 sck = 1;
      #20 sck = 0;
    end
    #60;
    n_cmp++;
    if (idle_act !== 1'b0 || rxq.size() != 0) begin
      n_fail++;
      $display("FAIL idle_noise: got activity=%b rx_pulses=%0d want 0 and 0", idle_act, rxq.size());
    end
  endtask

  task automatic test_abort;
    rxq.delete(); ferr_seen = 0;
    frame_start();
    send_bits(8'($urandom), 5);
    frame_end();
    n_cmp++;
    if (ferr_seen != 1 || rxq.size() != 0) begin
      n_fail++;
      $display("FAIL abort_pulses: got frame_err=%0d rx_valid=%0d want 1 and 0", ferr_seen, rxq.size());
    end
    n_cmp++;
    if (rx_data !== last_rx) begin
      n_fail++;
      $display("FAIL abort_rx_data: got %h want %h", rx_data, last_rx);
    end
    frame_q.delete(); frame_q.push_back(8'hFF);
    test_frame("after_abort", 8'($urandom));
  endtask

  task automatic test_reset_mid;
    frame_start();
    send_bits(8'($urandom), 4);
    #1 rst = 0;
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, byte_cnt, busy, frame_err, miso} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rx_data=%h rx_valid=%b byte_cnt=%0d busy=%b frame_err=%b miso=%b want all 0",
               rx_data, rx_valid, byte_cnt, busy, frame_err, miso);
    end
    last_rx = 0;
    #8 rst = 1;
    rxq.delete();
    send_bits(8'($urandom), 8);
    #60;
    n_cmp++;
    if (rxq.size() != 0 || busy !== 1'b0 || rx_data !== last_rx) begin
      n_fail++;
      $display("FAIL reset_no_resume: got rx_pulses=%0d busy=%b rx_data=%h want 0 0 00", rxq.size(), busy, rx_data);
    end
    ss = 1;
    #60;
    frame_q.delete(); frame_q.push_back(8'h81);
    test_frame("after_reset", 8'($urandom));
  endtask

  initial begin
    test_reset();
    test_idle_noise();
    frame_q.delete(); frame_q.push_back(8'h55);
    test_frame("single_55", 8'h00);
    foreach (frame_q[k]) ;
    frame_q.delete(); frame_q.push_back(8'h55); test_frame("sep_55", 8'($urandom));
    frame_q.delete(); frame_q.push_back(8'h05); test_frame("sep_05", 8'($urandom));
    frame_q.delete(); frame_q.push_back(8'h01); test_frame("sep_01", 8'($urandom));
    frame_q.delete(); frame_q.push_back(8'hA5); frame_q.push_back(8'h3C);
    test_frame("two_byte", 8'hC3);
    for (int f = 0; f < 3; f++) begin
      frame_q.delete();
      repeat ($urandom_range(1, 4)) frame_q.push_back(8'($urandom));
      test_frame("random_frame", 8'($urandom));
    end
    frame_q.delete();
    repeat (17) frame_q.push_back(8'($urandom));
    test_frame("cnt_wrap", 8'($urandom));
    test_abort();
    test_reset_mid();
    n_cmp++;
    if (both_seen) begin
      n_fail++;
      $display("FAIL no_overlap: got rx_valid and frame_err together want never");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
